// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace buffer.
// WB_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to every entry.
package wb_trace_pkg;

  localparam int unsigned OVF_W      = 16;
  localparam int unsigned ENTRY_XLEN = 32;
  localparam int unsigned ENTRY_RA_W = 5;
  localparam int unsigned STAMP_W    = 32;

  typedef enum logic {
    TRACE_STOP = 1'b0,
    TRACE_RING = 1'b1
  } trace_mode_e;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] inst;
    logic [ENTRY_RA_W-1:0] addr;
    logic [ENTRY_XLEN-1:0] data;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0]    stamp;
`endif
  } entry_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: DEPTH x entry_t, one write port, one combinational read port.
module wb_trace_mem
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO with STOP/RING overflow policy and saturating drop counter.
// Optional WB_TRACE_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned RA_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     cap_en,
  input  logic                     mode,
  input  logic                     wb_we,
  input  logic [RA_W-1:0]          wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [XLEN-1:0]          wb_inst,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output entry_t                   rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         ovf_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [OVF_W-1:0] ovf_q, ovf_n;
  logic             push_req, pop, full, mem_we;
  trace_mode_e      mode_e;
  entry_t           wr_entry;

  always_comb begin
    mode_e   = trace_mode_e'(mode);
    push_req = cap_en && wb_we && (wb_addr != '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = (count_q != '0) && rd_ready;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_q;
    ovf_n    = ovf_q;
    mem_we   = 1'b0;
    if (clear) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = '0;
    end else begin
      if (pop) begin
        rd_ptr_n = rd_ptr + PTR_W'(1);
      end
      if (push_req) begin
        // Full with a same-cycle pop: the write lands in the slot being vacated.
        if (!full || pop) begin
          mem_we   = 1'b1;
          wr_ptr_n = wr_ptr + PTR_W'(1);
          if (!pop) begin
            count_n = count_q + CNT_W'(1);
          end
        end else begin
          if (ovf_q != '1) begin
            ovf_n = ovf_q + OVF_W'(1);
          end
          if (mode_e == TRACE_RING) begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + PTR_W'(1);
            rd_ptr_n = rd_ptr + PTR_W'(1);
          end
        end
      end else if (pop) begin
        count_n = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      ovf_q   <= ovf_n;
    end
  end

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
    end
  end
`endif

  always_comb begin
    wr_entry       = '0;
    wr_entry.inst  = wb_inst;
    wr_entry.addr  = wb_addr;
    wr_entry.data  = wb_data;
`ifdef WB_TRACE_TIMESTAMP_EN
    wr_entry.stamp = stamp_q;
`endif
  end

  wb_trace_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign ovf_cnt  = ovf_q;

endmodule
